// File: rtl/flash_prog_if.sv
// Command-side bundle for flash_prog_seq: request handshake plus status pulses.
// A command transfers on a rising edge where cmd_valid && cmd_ready are both high; cmd_op/addr/data must be stable while cmd_valid is high, and valid never waits on ready.
interface flash_prog_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        busy;
  logic        done;
  logic        error;

  modport master (output cmd_valid, cmd_op, cmd_addr, cmd_data,
                  input  cmd_ready, busy, done, error);
  modport slave  (input  cmd_valid, cmd_op, cmd_addr, cmd_data,
                  output cmd_ready, busy, done, error);
endinterface

// File: rtl/flash_prog_seq.sv
// NOR-flash command sequencer: replays unlock/command bus-write cycles, then waits
// for RY/BY# release with a timeout. All strobes and status bits are registered.
module flash_prog_seq #(
  parameter int WE_CYCLES = 2,
  parameter int BUSY_DLY  = 4,
  parameter int TIMEOUT_W = 20
) (
  input  logic        CLKCPU,
  input  logic        RESET,
  flash_prog_if.slave cmd,
  input  logic        FLASH_BUSY_n,
  output logic [19:0] FLASH_A,
  output logic [15:0] FLASH_DQ_OUT,
  output logic        FLASH_DQ_OE,
  output logic        FLASH_CE_n,
  output logic        FLASH_WE_n,
  output logic        FLASH_OE_n,
  output logic [3:0]  o_dbg_state
);
  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_WE_LOW, S_HOLD, S_GAP,
    S_BUSY_DLY, S_WAIT_BUSY, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0] OP_PROG = 2'd0;
  localparam logic [1:0] OP_SECT = 2'd1;
  localparam logic [1:0] OP_READ = 2'd3;
  localparam logic [3:0] WE_LAST  = 4'(WE_CYCLES - 1);
  localparam logic [3:0] DLY_LAST = 4'(BUSY_DLY - 1);
  // Timeout fires on the cycle the counter would step onto all-ones.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  function automatic logic [35:0] wr_entry(input logic [1:0] op, input logic [2:0] idx,
                                           input logic [19:0] addr, input logic [15:0] data);
    logic [35:0] e;
    e = {20'h00000, 16'h00F0};
    if (op != OP_READ) begin
      case (idx)
        3'd0:    e = {20'h00555, 16'h00AA};
        3'd1:    e = {20'h002AA, 16'h0055};
        3'd2:    e = (op == OP_PROG) ? {20'h00555, 16'h00A0} : {20'h00555, 16'h0080};
        3'd3:    e = (op == OP_PROG) ? {addr, data} : {20'h00555, 16'h00AA};
        3'd4:    e = {20'h002AA, 16'h0055};
        default: e = (op == OP_SECT) ? {addr, 16'h0030} : {20'h00555, 16'h0010};
      endcase
    end
    return e;
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] op);
    logic [2:0] l;
    l = 3'd5;
    if (op == OP_PROG) l = 3'd3;
    else if (op == OP_READ) l = 3'd0;
    return l;
  endfunction

  state_t                r_state;
  logic [1:0]            r_op;
  logic [19:0]           r_addr;
  logic [15:0]           r_data;
  logic [2:0]            r_idx;
  logic [3:0]            r_cnt;
  logic [TIMEOUT_W-1:0]  r_to;
  logic                  r_sync1, r_sync2;
  logic [19:0]           r_a;
  logic [15:0]           r_dq;
  logic                  r_dq_oe, r_ce_n, r_we_n, r_oe_n;
  logic                  r_busy, r_ready, r_done, r_error;

  logic [2:0]  w_idx_nxt;
  logic [35:0] w_first_wr;
  logic [35:0] w_next_wr;
  logic        w_last;

  assign w_idx_nxt  = r_idx + 3'd1;
  assign w_first_wr = wr_entry(cmd.cmd_op, 3'd0, cmd.cmd_addr, cmd.cmd_data);
  assign w_next_wr  = wr_entry(r_op, w_idx_nxt, r_addr, r_data);
  assign w_last     = (r_idx == last_idx(r_op));

  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_op    <= 2'd0;
      r_addr  <= 20'd0;
      r_data  <= 16'd0;
      r_idx   <= 3'd0;
      r_cnt   <= 4'd0;
      r_to    <= '0;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_a     <= 20'd0;
      r_dq    <= 16'd0;
      r_dq_oe <= 1'b0;
      r_ce_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_sync1 <= FLASH_BUSY_n;
      r_sync2 <= r_sync1;
      r_oe_n  <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: if (cmd.cmd_valid && r_ready) begin
          r_op        <= cmd.cmd_op;
          r_addr      <= cmd.cmd_addr;
          r_data      <= cmd.cmd_data;
          r_idx       <= 3'd0;
          {r_a, r_dq} <= w_first_wr;
          r_ce_n      <= 1'b0;
          r_we_n      <= 1'b1;
          r_dq_oe     <= 1'b1;
          r_busy      <= 1'b1;
          r_ready     <= 1'b0;
          r_state     <= S_SETUP;
        end
        S_SETUP: begin
          r_we_n  <= 1'b0;
          r_cnt   <= 4'd0;
          r_state <= S_WE_LOW;
        end
        S_WE_LOW: if (r_cnt == WE_LAST) begin
          r_we_n  <= 1'b1;
          r_state <= S_HOLD;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
        S_HOLD: begin
          r_ce_n  <= 1'b1;
          r_dq_oe <= 1'b0;
          r_state <= S_GAP;
        end
        S_GAP: if (!w_last) begin
          r_idx       <= w_idx_nxt;
          {r_a, r_dq} <= w_next_wr;
          r_ce_n      <= 1'b0;
          r_dq_oe     <= 1'b1;
          r_state     <= S_SETUP;
        end else begin
          r_idx <= 3'd0;
          if (r_op == OP_READ) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= 4'd0;
            r_state <= S_BUSY_DLY;
          end
        end
        S_BUSY_DLY: if (r_cnt == DLY_LAST) begin
          r_to    <= '0;
          r_state <= S_WAIT_BUSY;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
        // Release is checked before the timeout so a same-cycle race completes normally.
        S_WAIT_BUSY: if (r_sync2) begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end else if (r_to == TO_LAST) begin
          r_error <= 1'b1;
          r_state <= S_ERROR;
        end else begin
          r_to <= r_to + 1'b1;
        end
        S_DONE, S_ERROR: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_idx   <= 3'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready = r_ready;
  assign cmd.busy      = r_busy;
  assign cmd.done      = r_done;
  assign cmd.error     = r_error;
  assign FLASH_A       = r_a;
  assign FLASH_DQ_OUT  = r_dq;
  assign FLASH_DQ_OE   = r_dq_oe;
  assign FLASH_CE_n    = r_ce_n;
  assign FLASH_WE_n    = r_we_n;
  assign FLASH_OE_n    = r_oe_n;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_flash_prog_seq.sv
// Randomized bench for flash_prog_seq: expected write lists and completion cycle
// come from a cycle-count model of the command rules.
module tb_flash_prog_seq;
  localparam int WE = 2;
  localparam int BD = 4;
  localparam int TW = 8;
  localparam int TO = (1 << TW) - 1;

  logic        clk;
  logic        RESET;
  logic        FLASH_BUSY_n;
  logic [19:0] FLASH_A;
  logic [15:0] FLASH_DQ_OUT;
  logic        FLASH_DQ_OE, FLASH_CE_n, FLASH_WE_n, FLASH_OE_n;
  logic [3:0]  o_dbg_state;

  flash_prog_if bus ();

  flash_prog_seq #(.WE_CYCLES(WE), .BUSY_DLY(BD), .TIMEOUT_W(TW)) dut (
    .CLKCPU(clk), .RESET(RESET), .cmd(bus), .FLASH_BUSY_n(FLASH_BUSY_n),
    .FLASH_A(FLASH_A), .FLASH_DQ_OUT(FLASH_DQ_OUT), .FLASH_DQ_OE(FLASH_DQ_OE),
    .FLASH_CE_n(FLASH_CE_n), .FLASH_WE_n(FLASH_WE_n), .FLASH_OE_n(FLASH_OE_n),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: write list of each operation
  task automatic build_exp(input logic [1:0] op, input logic [19:0] addr, input logic [15:0] data);
    logic [35:0] u1, u2;
    u1 = {20'h555, 16'h00AA};
    u2 = {20'h2AA, 16'h0055};
    exp_q.delete();
    case (op)
      2'd0: exp_q = '{u1, u2, {20'h555, 16'h00A0}, {addr, data}};
      2'd1: exp_q = '{u1, u2, {20'h555, 16'h0080}, u1, u2, {addr, 16'h0030}};
      2'd2: exp_q = '{u1, u2, {20'h555, 16'h0080}, u1, u2, {20'h555, 16'h0010}};
      default: exp_q = '{{20'h00000, 16'h00F0}};
    endcase
  endtask

  // driver + monitor: rel = cycle (after accept) at which RY/BY# is released,
  // hold_valid keeps a conflicting request up, abort_wr resets during that write's WE low
  task automatic run_cmd(input logic [1:0] op, input logic [19:0] addr, input logic [15:0] data,
                         input int rel, input bit hold_valid, input int abort_wr);
    int n, e_cyc, w, exp_end, cyc, bad_we, bad_oe, busy_lo, low_len, end_cyc, pulses, waitc;
    bit exp_err, prev_we, fin, got_err, aborted;
    build_exp(op, addr, data);
    n = exp_q.size();
    if (op == 2'd3) begin
      exp_end = n * (WE + 3);
      exp_err = 1'b0;
    end else begin
      e_cyc = n * (WE + 3) + BD;
      w = (rel + 2 > e_cyc) ? rel + 2 : e_cyc;
      if (w - e_cyc < TO) begin
        exp_end = w + 1;
        exp_err = 1'b0;
      end else begin
        exp_end = e_cyc + TO;
        exp_err = 1'b1;
      end
    end
    got_q.delete();
    waitc = 0;
    @(negedge clk);
    while (!bus.cmd_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("ready_before_cmd", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    FLASH_BUSY_n  = 1'b0;
    @(posedge clk);
    cyc = 0; bad_we = 0; bad_oe = 0; busy_lo = 0; low_len = 0; end_cyc = -1;
    prev_we = 1'b1; fin = 1'b0; got_err = 1'b0; aborted = 1'b0;
    while (!fin && cyc < 600) begin
      @(negedge clk);
      if (cyc == 0) begin
        if (hold_valid) begin
          bus.cmd_op   = op + 2'd1;
          bus.cmd_addr = 20'($urandom);
          bus.cmd_data = 16'($urandom);
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      if (!FLASH_WE_n && prev_we) begin
        got_q.push_back({FLASH_A, FLASH_DQ_OUT});
        low_len = 0;
      end
      if (!FLASH_WE_n) begin
        low_len++;
        if (FLASH_CE_n || !FLASH_DQ_OE) bad_we++;
      end
      if (FLASH_WE_n && !prev_we && low_len != WE) bad_we++;
      prev_we = FLASH_WE_n;
      if (!FLASH_OE_n) bad_oe++;
      if (!bus.busy || bus.cmd_ready) busy_lo++;
      if (abort_wr != 0 && got_q.size() == abort_wr && !FLASH_WE_n) begin
        bus.cmd_valid = 1'b0;
        RESET = 1'b1;
        #1;
        chk("abort_we_n", FLASH_WE_n, 1'b1);
        chk("abort_ce_n", FLASH_CE_n, 1'b1);
        chk("abort_dq_oe", FLASH_DQ_OE, 1'b0);
        chk("abort_addr", FLASH_A, 20'd0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_ready", bus.cmd_ready, 1'b1);
        pulses = 0;
        repeat (2) begin
          @(negedge clk);
          pulses += int'(bus.done) + int'(bus.error);
        end
        RESET = 1'b0;
        repeat (4) begin
          @(negedge clk);
          pulses += int'(bus.done) + int'(bus.error) + int'(bus.busy);
        end
        chk("abort_no_resume", pulses, 0);
        aborted = 1'b1;
        fin = 1'b1;
      end else if (bus.done || bus.error) begin
        end_cyc = cyc;
        got_err = bus.error;
        chk("single_outcome", bus.done & bus.error, 1'b0);
        bus.cmd_valid = 1'b0;
        fin = 1'b1;
      end
      if (cyc == rel) FLASH_BUSY_n = 1'b1;
      cyc++;
    end
    if (!fin) chk("end_within_budget", 1'b0, 1'b1);
    if (aborted || !fin) return;
    chk("n_writes", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("write_addr_data", got_q[i], exp_q[i]);
    chk("we_width_and_strobes", bad_we, 0);
    chk("oe_n_high", bad_oe, 0);
    chk("busy_throughout", busy_lo, 0);
    chk("outcome_is_error", got_err, exp_err);
    chk("end_cycle", end_cyc, exp_end);
    @(negedge clk);
    chk("post_ready", bus.cmd_ready, 1'b1);
    chk("post_busy", bus.busy, 1'b0);
    chk("post_pulses", {bus.done, bus.error}, 2'b00);
  endtask

  initial begin
    RESET = 1'b1;
    FLASH_BUSY_n = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_addr = 20'd0;
    bus.cmd_data = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.cmd_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_pulses", {bus.done, bus.error}, 2'b00);
    chk("rst_strobes", {FLASH_CE_n, FLASH_WE_n, FLASH_OE_n, FLASH_DQ_OE}, 4'b1110);
    chk("rst_addr", FLASH_A, 20'd0);
    chk("rst_dq", FLASH_DQ_OUT, 16'd0);
    RESET = 1'b0;

    run_cmd(2'd0, 20'h12345, 16'hBEEF, 10, 1'b0, 0);
    run_cmd(2'd1, 20'h40000, 16'h0000, 40, 1'b0, 0);
    run_cmd(2'd2, 20'h00000, 16'h0000, 3, 1'b0, 0);
    run_cmd(2'd3, 20'h00000, 16'h0000, 100000, 1'b0, 0);
    run_cmd(2'd0, 20'hABCDE, 16'h1234, 100000, 1'b0, 0);
    run_cmd(2'd0, 20'h00001, 16'h5A5A, 4 * (WE + 3) + BD + TO - 3, 1'b0, 0);
    run_cmd(2'd0, 20'h00002, 16'hA5A5, 4 * (WE + 3) + BD + TO - 2, 1'b0, 0);
    run_cmd(2'd0, 20'hFFFFF, 16'hFFFF, 0, 1'b1, 0);
    run_cmd(2'd0, 20'h11111, 16'h2222, 8, 1'b0, 3);
    run_cmd(2'd1, 20'h7F000, 16'h0000, 20, 1'b0, 0);

    for (int k = 0; k < 16; k++) begin
      logic [1:0] op;
      int e;
      op = 2'($urandom_range(3, 0));
      e = ((op == 2'd0) ? 4 : (op == 2'd3) ? 1 : 6) * (WE + 3) + BD;
      run_cmd(op, 20'($urandom), 16'($urandom), $urandom_range(e + 20, 0),
              1'($urandom_range(1, 0)), 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
